telemetry_timing: RTL

//  Timing master for the telemetry serializer (upstream strobe source). Divides clk_i into

---
 rtl/telem_pkg.sv | 21 ++
 rtl/telem_ce_divider.sv | 77 +++++++
 rtl/telemetry_timing.sv | 125 ++++++++++++
 3 files changed

// File: rtl/telem_pkg.sv
// Shared constants and types for the telemetry serializer timing path.
// Word geometry, frame marker words and the timing FSM state encoding.
package telem_pkg;

  localparam int WORD_BITS = 16;
  localparam int BIT_CNT_W = $clog2(WORD_BITS);

  localparam logic [BIT_CNT_W-1:0] BIT_LAST =
    BIT_CNT_W'(WORD_BITS - 1);

  localparam logic [15:0] SYNC_WORD  = 16'hEB90;
  localparam logic [15:0] IDLE_WORD  = 16'hB3A5;
  localparam logic [15:0] END_WORD_1 = 16'hC0FE;
  localparam logic [15:0] END_WORD_2 = 16'hD0CC;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } tstate_e;

endpackage

// File: rtl/telem_ce_divider.sv
// Half-bit divider: produces registered mid-bit and bit-boundary strobes.
// A divider value of 0 is treated as 1.
module telem_ce_divider #(
  parameter int DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tog_o,
  output logic             bit_o,
  output logic             bit_nxt_o
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] hc_q, hc_d;
  logic             ph_q, ph_d;
  logic             tog_q, tog_d;
  logic             bit_q, bit_d;
  logic [DIV_W-1:0] div_sat;
  logic [DIV_W-1:0] div_use;
  logic             term;

  always_comb begin
    div_sat = (div_i == '0) ? DIV_W'(1) : div_i;
    // a reload takes effect on the half-bit already in progress
    div_use = load_i ? div_sat : div_q;
    term    = (hc_q == div_use - DIV_W'(1));
    div_d   = div_q;
    hc_d    = hc_q;
    ph_d    = ph_q;
    tog_d   = 1'b0;
    bit_d   = 1'b0;
    if (clr_i) begin
      div_d = div_sat;
      hc_d  = '0;
      ph_d  = 1'b0;
    end else begin
      if (load_i) begin
        div_d = div_sat;
      end
      if (en_i) begin
        if (term) begin
          hc_d  = '0;
          ph_d  = ~ph_q;
          tog_d = ~ph_q;
          bit_d = ph_q;
        end else begin
          hc_d = hc_q + DIV_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      div_q <= DIV_W'(1);
      hc_q  <= '0;
      ph_q  <= 1'b0;
      tog_q <= 1'b0;
      bit_q <= 1'b0;
    end else begin
      div_q <= div_d;
      hc_q  <= hc_d;
      ph_q  <= ph_d;
      tog_q <= tog_d;
      bit_q <= bit_d;
    end
  end

  assign tog_o     = tog_q;
  assign bit_o     = bit_q;
  assign bit_nxt_o = bit_d;

endmodule

// File: rtl/telemetry_timing.sv
// Telemetry timing master: half-bit/bit/word/frame strobes for the serializer.
// Start, stop and rate changes only land on frame boundaries.
module telemetry_timing
  import telem_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int FRAME_WORDS = 1024
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] half_div_i,
  output logic             bittogce_o,
  output logic             bitce_o,
  output logic             wordce_o,
  output logic             syncce_o,
  output logic             running_o,
  output logic [15:0]      word_idx_o
);

  localparam logic [15:0] FW_LAST = 16'(FRAME_WORDS - 1);

  tstate_e              state_q, state_d;
  logic                 running_q, running_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [15:0]          word_cnt_q, word_cnt_d;
  logic                 wordce_q, wordce_d;
  logic                 syncce_q, syncce_d;

  logic start;
  logic stop;
  logic run;
  logic cnt_en;
  logic load;
  logic tog;
  logic bitce;
  logic bit_nxt;

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    stop    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (en_i) begin
          start   = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (syncce_q && !en_i) begin
          stop    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    run       = (state_q == ST_RUN);
    cnt_en    = run && !stop;
    load      = run && syncce_q;
    running_d = (state_d == ST_RUN);
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    if (start) begin
      bit_cnt_d  = '0;
      // first word boundary after start is a frame boundary
      word_cnt_d = FW_LAST;
    end else if (run) begin
      if (bitce) begin
        bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0
                  : bit_cnt_q + BIT_CNT_W'(1);
      end
      if (wordce_q) begin
        word_cnt_d = (word_cnt_q == FW_LAST) ? '0
                   : word_cnt_q + 16'd1;
      end
    end
    // counters advance after the strobe, so predict from current counts
    wordce_d = bit_nxt && (bit_cnt_q == BIT_LAST);
    syncce_d = wordce_d && (word_cnt_q == FW_LAST);
  end

  telem_ce_divider #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .clr_i     (start),
    .load_i    (load),
    .en_i      (cnt_en),
    .div_i     (half_div_i),
    .tog_o     (tog),
    .bit_o     (bitce),
    .bit_nxt_o (bit_nxt)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      running_q  <= 1'b0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      wordce_q   <= 1'b0;
      syncce_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      running_q  <= running_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      wordce_q   <= wordce_d;
      syncce_q   <= syncce_d;
    end
  end

  assign bittogce_o = tog;
  assign bitce_o    = bitce;
  assign wordce_o   = wordce_q;
  assign syncce_o   = syncce_q;
  assign running_o  = running_q;
  assign word_idx_o = word_cnt_q;

endmodule
